legv8_control_unit: RTL

- Multi-cycle LEGv8 control FSM driving the 64-bit datapath core's control-word inputs.
- Consumes the datapath's instruction register (IR) and 4-bit status flags; produces SA/SB/DA, FS, C0, k, tri-state selects, memory strobes and PC controls.
- Sits beside the datapath core at the CPU top level; one instruction in flight, no pipelining.

---
 rtl/legv8_ctrl_pkg.sv | 135 +++++++++++++
 rtl/legv8_cond_eval.sv | 43 ++++
 rtl/legv8_control_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/legv8_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | legv8_ctrl_pkg                                                       |
// | Shared types, opcode/FS/select codes and decode helpers for the      |
// | LEGv8 multi-cycle control unit.                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package legv8_ctrl_pkg;

    // Encoding is exported on state_dbg: INIT=0 .. HALT=5.
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        IC_NONE, IC_RTYPE, IC_ITYPE, IC_B, IC_BCOND,
        IC_BR, IC_LDUR, IC_STUR, IC_HLT
    } iclass_e;

    localparam logic [10:0] OP_ADD   = 11'h458;
    localparam logic [10:0] OP_ADDS  = 11'h558;
    localparam logic [10:0] OP_SUB   = 11'h658;
    localparam logic [10:0] OP_SUBS  = 11'h758;
    localparam logic [10:0] OP_AND   = 11'h450;
    localparam logic [10:0] OP_ORR   = 11'h550;
    localparam logic [10:0] OP_EOR   = 11'h650;
    localparam logic [10:0] OP_BR    = 11'h6B0;
    localparam logic [10:0] OP_HLT   = 11'h6A2;
    localparam logic [10:0] OP_LDUR  = 11'h7C2;
    localparam logic [10:0] OP_STUR  = 11'h7C0;
    localparam logic [9:0]  OP_ADDI  = 10'h244;
    localparam logic [9:0]  OP_ADDIS = 10'h2C4;
    localparam logic [9:0]  OP_SUBI  = 10'h344;
    localparam logic [9:0]  OP_SUBIS = 10'h3C4;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'h54;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;

    localparam logic [1:0] DBUS_ALU  = 2'b00;
    localparam logic [1:0] DBUS_REGB = 2'b01;
    localparam logic [1:0] DBUS_PC4  = 2'b10;
    localparam logic [1:0] DBUS_MEM  = 2'b11;

    localparam logic [1:0] PCFS_HOLD = 2'b00;
    localparam logic [1:0] PCFS_INC  = 2'b01;
    localparam logic [1:0] PCFS_REL  = 2'b10;
    localparam logic [1:0] PCFS_LOAD = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [4:0] fs;
        logic       c0;
        logic       set_flags;
    } alu_ctl_t;

    function automatic iclass_e classify(input logic [31:0] ir);
        iclass_e c;
        c = IC_NONE;
        case (ir[31:21])
            OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
            OP_AND, OP_ORR, OP_EOR:             c = IC_RTYPE;
            OP_BR:                              c = IC_BR;
            OP_HLT:                             c = IC_HLT;
            OP_LDUR:                            c = IC_LDUR;
            OP_STUR:                            c = IC_STUR;
            default:                            c = IC_NONE;
        endcase
        if (c == IC_NONE) begin
            case (ir[31:22])
                OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS: c = IC_ITYPE;
                default: begin
                    if (ir[31:26] == OP_B)
                        c = IC_B;
                    else if (ir[31:24] == OP_BCOND)
                        c = IC_BCOND;
                end
            endcase
        end
        return c;
    endfunction

    // Register and immediate ALU forms share one table: FS, carry-in, flag update.
    function automatic alu_ctl_t alu_decode(input logic [31:0] ir);
        alu_ctl_t a;
        a = '0;
        case (ir[31:21])
            OP_ADD:  a.fs = FS_ADD;
            OP_ADDS: begin a.fs = FS_ADD; a.set_flags = 1'b1; end
            OP_SUB:  begin a.fs = FS_SUB; a.c0 = 1'b1; end
            OP_SUBS: begin a.fs = FS_SUB; a.c0 = 1'b1; a.set_flags = 1'b1; end
            OP_AND:  a.fs = FS_AND;
            OP_ORR:  a.fs = FS_ORR;
            OP_EOR:  a.fs = FS_EOR;
            default: ;
        endcase
        case (ir[31:22])
            OP_ADDI:  a.fs = FS_ADD;
            OP_ADDIS: begin a.fs = FS_ADD; a.set_flags = 1'b1; end
            OP_SUBI:  begin a.fs = FS_SUB; a.c0 = 1'b1; end
            OP_SUBIS: begin a.fs = FS_SUB; a.c0 = 1'b1; a.set_flags = 1'b1; end
            default: ;
        endcase
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/legv8_cond_eval.sv
// +----------------------------------------------------------------------+
// | legv8_cond_eval                                                      |
// | Combinational B.cond evaluator: cond[3:0] vs {N,Z,C,V} -> taken.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module legv8_cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_status,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = i_status;

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = ~w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = ~w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = ~w_v;
            COND_HI: o_taken = w_c & ~w_z;
            COND_LS: o_taken = ~(w_c & ~w_z);
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = ~w_z & (w_n == w_v);
            COND_LE: o_taken = ~(~w_z & (w_n == w_v));
            COND_AL, COND_NV: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/legv8_control_unit.sv
// +----------------------------------------------------------------------+
// | legv8_control_unit                                                   |
// | Multi-cycle LEGv8 control FSM (INIT/FETCH/DECODE/EXEC/MEM/HALT).     |
// | Option: LEGV8_CTRL_TRAP_EN traps unknown opcodes to HALT and adds    |
// | the sticky illegal_op output.                                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter logic [1:0] FETCH_SIZE = 2'b10,
    parameter logic [1:0] DATA_SIZE  = 2'b11
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  status,
    output logic        w_reg,
    output logic        C0,
    output logic        mem_cs,
    output logic        mem_write_en,
    output logic        IR_load,
    output logic        status_load,
    output logic        B_Sel,
    output logic        PC_sel,
    output logic        add_tri_sel,
    output logic [31:0] k,
    output logic [4:0]  FS,
    output logic [1:0]  PC_FS,
    output logic [1:0]  size,
    output logic [1:0]  data_tri_sel,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        halted,
    output logic [2:0]  state_dbg
`ifdef LEGV8_CTRL_TRAP_EN
    ,
    output logic        illegal_op
`endif
);

    state_e   state_q, state_d;
    iclass_e  w_cls;
    alu_ctl_t w_alu;
    logic     w_taken;

    assign w_cls     = classify(IR);
    assign w_alu     = alu_decode(IR);
    assign state_dbg = state_q;

    legv8_cond_eval u_cond_eval (
        .i_cond   (IR[3:0]),
        .i_status (status),
        .o_taken  (w_taken)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (w_cls)
                    IC_LDUR, IC_STUR: state_d = ST_MEM;
                    IC_HLT:           state_d = ST_HALT;
`ifdef LEGV8_CTRL_TRAP_EN
                    IC_NONE:          state_d = ST_HALT;
`endif
                    default:          state_d = ST_EXEC;
                endcase
            end
            ST_EXEC, ST_MEM: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

`ifdef LEGV8_CTRL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d  = illegal_q | ((state_q == ST_DECODE) && (w_cls == IC_NONE));
    assign illegal_op = illegal_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
`ifdef LEGV8_CTRL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef LEGV8_CTRL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        w_reg        = 1'b0;
        C0           = 1'b0;
        mem_cs       = 1'b0;
        mem_write_en = 1'b0;
        IR_load      = 1'b0;
        status_load  = 1'b0;
        B_Sel        = 1'b0;
        PC_sel       = 1'b0;
        add_tri_sel  = 1'b0;
        k            = 32'd0;
        FS           = 5'd0;
        PC_FS        = PCFS_HOLD;
        size         = 2'b00;
        data_tri_sel = DBUS_ALU;
        SA           = 5'd0;
        SB           = 5'd0;
        DA           = 5'd0;
        halted       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                add_tri_sel  = 1'b1;
                mem_cs       = 1'b1;
                data_tri_sel = DBUS_MEM;
                size         = FETCH_SIZE;
                IR_load      = 1'b1;
                PC_FS        = PCFS_INC;
            end
            ST_EXEC: begin
                case (w_cls)
                    IC_RTYPE, IC_ITYPE: begin
                        SA           = IR[9:5];
                        DA           = IR[4:0];
                        w_reg        = 1'b1;
                        data_tri_sel = DBUS_ALU;
                        FS           = w_alu.fs;
                        C0           = w_alu.c0;
                        status_load  = w_alu.set_flags;
                        if (w_cls == IC_RTYPE) begin
                            SB = IR[20:16];
                        end else begin
                            B_Sel = 1'b1;
                            k     = {20'd0, IR[21:10]};
                        end
                    end
                    // Branch offsets are word counts; -1 undoes the PC+4 already applied in FETCH.
                    IC_B: begin
                        PC_sel = 1'b1;
                        PC_FS  = PCFS_REL;
                        k      = {{6{IR[25]}}, IR[25:0]} - 32'd1;
                    end
                    IC_BCOND: begin
                        if (w_taken) begin
                            PC_sel = 1'b1;
                            PC_FS  = PCFS_REL;
                            k      = {{13{IR[23]}}, IR[23:5]} - 32'd1;
                        end
                    end
                    IC_BR: begin
                        SA    = IR[9:5];
                        PC_FS = PCFS_LOAD;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                SA     = IR[9:5];
                B_Sel  = 1'b1;
                k      = {{23{IR[20]}}, IR[20:12]};
                FS     = FS_ADD;
                mem_cs = 1'b1;
                size   = DATA_SIZE;
                if (w_cls == IC_LDUR) begin
                    data_tri_sel = DBUS_MEM;
                    DA           = IR[4:0];
                    w_reg        = 1'b1;
                end else if (w_cls == IC_STUR) begin
                    SB           = IR[4:0];
                    data_tri_sel = DBUS_REGB;
                    mem_write_en = 1'b1;
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire
